// File: rtl/loader_pkg.sv
// Shared types and defaults for the RAM program loader.
// LOADER_VERIFY_EN adds the read-back verify states.
package loader_pkg;

  localparam int unsigned DefAddrW = 4;
  localparam int unsigned DefDataW = 8;

  typedef logic [2:0] state_t;

  localparam state_t StIdle     = 3'd0;
  localparam state_t StHold     = 3'd1;
  localparam state_t StFetch    = 3'd2;
  localparam state_t StWrite    = 3'd3;
  localparam state_t StResetCpu = 3'd4;
`ifdef LOADER_VERIFY_EN
  localparam state_t StVfetch   = 3'd5;
  localparam state_t StVcheck   = 3'd6;
`endif

endpackage

// File: rtl/ram_program_loader_edge_sync.sv
// Two-flop synchronizer with a rising-edge pulse output.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic       s1_q, s2_q, prev_q, armed_q;
  logic [1:0] vld_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      s1_q   <= din;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      vld_q  <= {vld_q[0], 1'b1};
      // Only arm once a genuine low has been sampled, so a level held through reset is no edge.
      if (vld_q[1] && !s2_q) armed_q <= 1'b1;
    end
  end

  assign pulse = s2_q & ~prev_q & armed_q;

endmodule

// File: rtl/ram_program_loader.sv
// Copies a boot ROM image into the CPU RAM while holding the CPU, then pulses CPU reset.
// LOADER_VERIFY_EN adds a read-back verify pass with ram_rdata / verify_err.
module ram_program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned RST_CYCLES  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] cpu_ram_addr,
  input  logic [DATA_W-1:0] cpu_ram_wdata,
  input  logic              cpu_ram_we,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              cpu_hold,
  output logic              cpu_reset,
  output logic              busy,
`ifdef LOADER_VERIFY_EN
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              verify_err,
`endif
  output logic              done
);

  localparam int unsigned MaxCyc = (HOLD_CYCLES > RST_CYCLES) ? HOLD_CYCLES : RST_CYCLES;
  localparam int unsigned CycW   = $clog2(MaxCyc + 1);
  localparam logic [CycW-1:0]   HoldLast = CycW'(HOLD_CYCLES - 1);
  localparam logic [CycW-1:0]   RstLast  = CycW'(RST_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LastAddr = {ADDR_W{1'b1}};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [CycW-1:0]   cyc_q, cyc_d;
  logic [ADDR_W-1:0] rom_addr_q;
  logic              done_q, done_d;
  logic              start;
  logic              fetching;
`ifdef LOADER_VERIFY_EN
  logic              verr_q, verr_d;
`endif

  edge_sync u_edge_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (load_req),
    .pulse (start)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    done_d  = done_q;
`ifdef LOADER_VERIFY_EN
    verr_d  = verr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StHold;
          done_d  = 1'b0;
          cnt_d   = '0;
          cyc_d   = '0;
`ifdef LOADER_VERIFY_EN
          verr_d  = 1'b0;
`endif
        end
      end
      StHold: begin
        if (cyc_q == HoldLast) begin
          state_d = StFetch;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      StFetch: state_d = StWrite;
      StWrite: begin
        if (cnt_q == LastAddr) begin
`ifdef LOADER_VERIFY_EN
          state_d = StVfetch;
          cnt_d   = '0;
`else
          state_d = StResetCpu;
`endif
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = StFetch;
        end
      end
`ifdef LOADER_VERIFY_EN
      StVfetch: state_d = StVcheck;
      StVcheck: begin
        if (ram_rdata != rom_data) verr_d = 1'b1;
        if (cnt_q == LastAddr) begin
          state_d = StResetCpu;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = StVfetch;
        end
      end
`endif
      StResetCpu: begin
        if (cyc_q == RstLast) begin
          state_d = StIdle;
          done_d  = 1'b1;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      cyc_q      <= '0;
      rom_addr_q <= '0;
      done_q     <= 1'b0;
`ifdef LOADER_VERIFY_EN
      verr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cyc_q      <= cyc_d;
      rom_addr_q <= rom_addr;
      done_q     <= done_d;
`ifdef LOADER_VERIFY_EN
      verr_q     <= verr_d;
`endif
    end
  end

`ifdef LOADER_VERIFY_EN
  assign fetching   = (state_q == StFetch) || (state_q == StVfetch);
  assign verify_err = verr_q;
`else
  assign fetching   = (state_q == StFetch);
`endif

  // ROM address is only advanced while fetching and holds otherwise.
  assign rom_addr  = fetching ? cnt_q : rom_addr_q;
  assign busy      = (state_q != StIdle);
  assign cpu_hold  = busy;
  assign cpu_reset = (state_q == StResetCpu);
  assign done      = done_q;

  always_comb begin
    if (state_q == StIdle) begin
      ram_addr  = cpu_ram_addr;
      ram_wdata = cpu_ram_wdata;
      ram_we    = cpu_ram_we;
    end else begin
      ram_addr  = cnt_q;
      ram_wdata = rom_data;
      ram_we    = (state_q == StWrite);
    end
  end

endmodule

// File: tb/tb_ram_program_loader.sv
// Self-checking bench for ram_program_loader: timeline model plus directed scenarios.
module tb_ram_program_loader;

  localparam int Words   = 16;
  localparam int HoldCyc = 16;
  localparam int RstCyc  = 4;
  localparam int VB      = HoldCyc + 2 * Words;
`ifdef LOADER_VERIFY_EN
  localparam int VerT    = 2 * Words;
  localparam int BadAddr = 3;
`else
  localparam int VerT    = 0;
`endif
  localparam int RstT    = VB + VerT;
  localparam int EndT    = RstT + RstCyc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_req = 1'b0;
  logic [3:0] cpu_ram_addr = '0;
  logic [7:0] cpu_ram_wdata = '0;
  logic       cpu_ram_we = 1'b0;
  logic [3:0] rom_addr;
  logic [7:0] rom_data = '0;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we, cpu_hold, cpu_reset, busy, done;
`ifdef LOADER_VERIFY_EN
  logic [7:0] ram_rdata = '0;
  logic       verify_err;
`endif

  int checks = 0;
  int errors = 0;

  ram_program_loader #(
    .ADDR_W      (4),
    .DATA_W      (8),
    .HOLD_CYCLES (HoldCyc),
    .RST_CYCLES  (RstCyc)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_req      (load_req),
    .cpu_ram_addr  (cpu_ram_addr),
    .cpu_ram_wdata (cpu_ram_wdata),
    .cpu_ram_we    (cpu_ram_we),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata),
    .ram_we        (ram_we),
    .cpu_hold      (cpu_hold),
    .cpu_reset     (cpu_reset),
    .busy          (busy),
`ifdef LOADER_VERIFY_EN
    .ram_rdata     (ram_rdata),
    .verify_err    (verify_err),
`endif
    .done          (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_val(input int i);
    return 8'(16 + i);
  endfunction

  logic [7:0] mem [Words];

  always @(posedge clk) rom_data <= rom_val(int'(rom_addr));

  always @(posedge clk) begin
`ifdef LOADER_VERIFY_EN
    ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= (int'(ram_addr) == BadAddr) ? 8'h00 : ram_wdata;
`else
    if (ram_we) mem[ram_addr] <= ram_wdata;
`endif
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_t counts cycles since the start of a load (-1 when idle).
  int         m_t = -1;
  int         m_n = 0;
  logic [2:0] m_h = '0;
  logic       m_done = 1'b0;
  logic       m_verr = 1'b0;
  logic [3:0] m_rom_last = '0;
  bit         cmp_en = 1'b0;

  always @(negedge clk) begin : model_cmp
    bit fe, wr, vfe, start;
    int fa, wa, va;
    fe  = m_t >= HoldCyc && m_t < VB && ((m_t - HoldCyc) % 2 == 0);
    wr  = m_t >  HoldCyc && m_t < VB && ((m_t - HoldCyc) % 2 == 1);
    vfe = m_t >= VB && m_t < RstT && ((m_t - VB) % 2 == 0);
    fa  = (m_t - HoldCyc) / 2;
    wa  = (m_t - HoldCyc - 1) / 2;
    va  = (m_t - VB) / 2;
    if (cmp_en) begin
      chk("busy", 32'(busy), 32'(m_t >= 0));
      chk("cpu_hold", 32'(cpu_hold), 32'(m_t >= 0));
      chk("cpu_reset", 32'(cpu_reset), 32'(m_t >= RstT));
      chk("done", 32'(done), 32'(m_done));
      chk("rom_addr", 32'(rom_addr), fe ? 32'(fa) : (vfe ? 32'(va) : 32'(m_rom_last)));
      if (m_t < 0) begin
        chk("pass_addr", 32'(ram_addr), 32'(cpu_ram_addr));
        chk("pass_wdata", 32'(ram_wdata), 32'(cpu_ram_wdata));
        chk("pass_we", 32'(ram_we), 32'(cpu_ram_we));
      end else begin
        chk("load_we", 32'(ram_we), 32'(wr));
        if (wr) begin
          chk("load_addr", 32'(ram_addr), 32'(wa));
          chk("load_wdata", 32'(ram_wdata), 32'(rom_val(wa)));
        end
        if (vfe) chk("verify_addr", 32'(ram_addr), 32'(va));
      end
`ifdef LOADER_VERIFY_EN
      chk("verify_err", 32'(verify_err), 32'(m_verr));
`endif
    end
    if (!rst_n) begin
      m_t = -1; m_done = 1'b0; m_verr = 1'b0; m_rom_last = '0; m_n = 0; m_h = '0;
    end else begin
      start = (m_t < 0) && m_n >= 3 && m_h[1] && !m_h[2];
      if (fe) m_rom_last = 4'(fa);
      else if (vfe) m_rom_last = 4'(va);
`ifdef LOADER_VERIFY_EN
      if (m_t >= VB && m_t < RstT && ((m_t - VB) % 2 == 1) && va == BadAddr) m_verr = 1'b1;
`endif
      if (m_t >= 0) begin
        m_t++;
        if (m_t == EndT) begin
          m_t = -1;
          m_done = 1'b1;
        end
      end else if (start) begin
        m_t = 0; m_done = 1'b0; m_verr = 1'b0;
      end
      m_h = {m_h[1:0], load_req};
      if (m_n < 3) m_n++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] ldmem [Words];

  initial begin : stim
    int n_wr, n_busy, n_rst, n_rise, n_cpuwr, first_hold, rel;
    bit pressed2, prev_done, found;

    // Reset, then CPU passthrough in idle.
    tick();
    cmp_en = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    repeat (4) tick();
    cpu_ram_addr = 4'd5; cpu_ram_wdata = 8'hA3; cpu_ram_we = 1'b1;
    #1;
    chk("idle_addr", 32'(ram_addr), 32'd5);
    chk("idle_wdata", 32'(ram_wdata), 32'hA3);
    chk("idle_we", 32'(ram_we), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_rom_addr", 32'(rom_addr), 32'd0);

    // Full load with CPU writes asserted throughout and a second press at address 7.
    tick();
    cpu_ram_wdata = 8'hEE;
    load_req = 1'b1;
    n_wr = 0; n_busy = 0; n_rst = 0; n_rise = 0; n_cpuwr = 0;
    first_hold = -1; pressed2 = 1'b0; prev_done = done; rel = -1;
    for (int c = 0; c < 130; c++) begin
      tick();
      cpu_ram_addr = 4'(c);
      if (c == 3) load_req = 1'b0;
      if (busy) n_busy++;
      if (cpu_reset) n_rst++;
      if (cpu_hold && first_hold < 0) first_hold = c;
      if (busy && ram_we) begin
        n_wr++;
        ldmem[ram_addr] = ram_wdata;
        if (ram_wdata == 8'hEE) n_cpuwr++;
        if (ram_addr == 4'd7 && !pressed2) begin
          load_req = 1'b1; pressed2 = 1'b1; rel = c + 3;
        end
      end
      if (c == rel) load_req = 1'b0;
      if (done && !prev_done) n_rise++;
      prev_done = done;
    end
    chk("hold_latency", 32'(first_hold), 32'd2);
    chk("write_count", 32'(n_wr), 32'd16);
    chk("busy_cycles", 32'(n_busy), 32'(EndT));
    chk("reset_cycles", 32'(n_rst), 32'd4);
    chk("done_rises", 32'(n_rise), 32'd1);
    chk("cpu_writes_in_load", 32'(n_cpuwr), 32'd0);
    chk("done_after", 32'(done), 32'd1);
    for (int i = 0; i < Words; i++) chk("image", 32'(ldmem[i]), 32'(8'h10 + 8'(i)));
`ifdef LOADER_VERIFY_EN
    chk("verify_err_set", 32'(verify_err), 32'd1);
`endif

    // Reset for one cycle during FETCH of address 9.
    cpu_ram_we = 1'b0;
    load_req = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (c == 3) load_req = 1'b0;
      if (busy && rom_addr == 4'd9 && !ram_we) begin
        found = 1'b1;
        break;
      end
    end
    chk("fetch9_reached", 32'(found), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cpu_ram_addr = 4'hC; cpu_ram_wdata = 8'h5A; cpu_ram_we = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_hold", 32'(cpu_hold), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_addr", 32'(ram_addr), 32'hC);
    chk("mid_rst_wdata", 32'(ram_wdata), 32'h5A);
    chk("mid_rst_we", 32'(ram_we), 32'd1);

    // Button held through reset must not start a load.
    tick();
    cpu_ram_we = 1'b0;
    load_req = 1'b1;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("held_no_start", 32'(busy), 32'd0);
    load_req = 1'b0;
    repeat (4) tick();

    // Normal load after that; done and verify_err clear at start.
    load_req = 1'b1;
    repeat (3) tick();
    load_req = 1'b0;
    repeat (4) tick();
    chk("reload_busy", 32'(busy), 32'd1);
    chk("reload_done_clr", 32'(done), 32'd0);
`ifdef LOADER_VERIFY_EN
    chk("reload_verr_clr", 32'(verify_err), 32'd0);
`endif
    repeat (EndT) tick();
    chk("reload_done", 32'(done), 32'd1);
    chk("reload_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
